// File: rtl/axon_spike_scheduler.sv
// Circular per-tick axon spike buffer: packets mark a bit in a future tick slot,
// neuron_grid loads/clears the current slot, and the tick pulse advances the pointer.
module axon_spike_scheduler #(
    parameter int NUM_AXONS = 256,
    parameter int AXON_W    = 8,
    parameter int NUM_SLOTS = 16,
    parameter int DELAY_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 packet_valid,
    output logic                 packet_ready,
    input  logic [AXON_W-1:0]    packet_axon,
    input  logic [DELAY_W-1:0]   packet_delay,
    input  logic                 scheduler_set,
    input  logic                 scheduler_clr,
    output logic [NUM_AXONS-1:0] axon_spikes,
    output logic [DELAY_W-1:0]   slot_ptr,
    output logic                 error_delay
);

    logic [NUM_AXONS-1:0] r_slots [NUM_SLOTS];
    logic [NUM_AXONS-1:0] r_axon_spikes;
    logic [DELAY_W-1:0]   r_slot_ptr;
    logic                 r_error_delay;

    logic                 w_accept;
    logic                 w_delay_zero;
    logic                 w_write;
    logic [DELAY_W-1:0]   w_target;

    // Handshake decode: a tick cycle stalls the producer for one cycle.
    always_comb begin
        w_accept     = 1'b0;
        w_delay_zero = 1'b0;
        w_write      = 1'b0;
        w_target     = r_slot_ptr + packet_delay;
        if (packet_valid && !tick) begin
            w_accept     = 1'b1;
            w_delay_zero = (packet_delay == {DELAY_W{1'b0}});
            w_write      = (packet_delay != {DELAY_W{1'b0}});
        end else begin
            w_accept     = 1'b0;
            w_delay_zero = 1'b0;
            w_write      = 1'b0;
        end
    end

    // Slot pointer advances once per tick and wraps naturally at NUM_SLOTS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_ptr <= {DELAY_W{1'b0}};
        end else if (tick) begin
            r_slot_ptr <= r_slot_ptr + {{(DELAY_W-1){1'b0}}, 1'b1};
        end
    end

    // Slot storage: clear of the current slot, or OR-in of a scheduled spike.
    // A delay >= 1 never targets the current slot, so the two cannot collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                r_slots[k] <= {NUM_AXONS{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (scheduler_clr && (r_slot_ptr == DELAY_W'(k))) begin
                    r_slots[k] <= {NUM_AXONS{1'b0}};
                end else if (w_write && (w_target == DELAY_W'(k))) begin
                    r_slots[k][packet_axon] <= 1'b1;
                end
            end
        end
    end

    // Output vector captures the pre-clear slot contents on set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_axon_spikes <= {NUM_AXONS{1'b0}};
        end else if (scheduler_set) begin
            r_axon_spikes <= r_slots[r_slot_ptr];
        end
    end

    // One-cycle error pulse for an accepted packet with zero delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error_delay <= 1'b0;
        end else begin
            r_error_delay <= w_accept && w_delay_zero;
        end
    end

    assign packet_ready = ~tick;
    assign axon_spikes  = r_axon_spikes;
    assign slot_ptr     = r_slot_ptr;
    assign error_delay  = r_error_delay;

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Directed vector bench for axon_spike_scheduler: table rows plus hand sequences
// for the slot scans and the asynchronous mid-operation reset.
module tb_axon_spike_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         tick, packet_valid, scheduler_set, scheduler_clr;
    logic [7:0]   packet_axon;
    logic [3:0]   packet_delay;
    logic         packet_ready, error_delay;
    logic [255:0] axon_spikes;
    logic [3:0]   slot_ptr;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic         tick;
        logic         valid;
        logic [7:0]   axon;
        logic [3:0]   delay;
        logic         set;
        logic         clr;
        int           rep;
        logic         exp_ready;
        logic [3:0]   exp_ptr;
        logic         exp_err;
        logic [255:0] exp_spk;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    axon_spike_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .packet_valid (packet_valid),
        .packet_ready (packet_ready),
        .packet_axon  (packet_axon),
        .packet_delay (packet_delay),
        .scheduler_set(scheduler_set),
        .scheduler_clr(scheduler_clr),
        .axon_spikes  (axon_spikes),
        .slot_ptr     (slot_ptr),
        .error_delay  (error_delay)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] m(input int a);
        logic [255:0] one;
        one = 256'd1;
        return one << a;
    endfunction

    function automatic vec_t mk(input logic t, input logic v, input int ax, input int d,
                                input logic s, input logic c, input int rep,
                                input logic er, input int ep, input logic ee,
                                input logic [255:0] es);
        vec_t x;
        x.tick = t; x.valid = v; x.axon = 8'(ax); x.delay = 4'(d);
        x.set = s; x.clr = c; x.rep = rep;
        x.exp_ready = er; x.exp_ptr = 4'(ep); x.exp_err = ee; x.exp_spk = es;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic t, input logic v, input logic [7:0] ax,
                         input logic [3:0] d, input logic s, input logic c);
        tick = t; packet_valid = v; packet_axon = ax; packet_delay = d;
        scheduler_set = s; scheduler_clr = c;
    endtask

    task automatic run_vec(input string tag, input int idx, input vec_t v);
        for (int r = 0; r < v.rep; r++) begin
            @(negedge clk);
            drive(v.tick, v.valid, v.axon, v.delay, v.set, v.clr);
            #1;
            if (r == 0) chk($sformatf("%s%0d ready", tag, idx), 256'(packet_ready), 256'(v.exp_ready));
            @(posedge clk);
            #1;
        end
        chk($sformatf("%s%0d ptr", tag, idx), 256'(slot_ptr), 256'(v.exp_ptr));
        chk($sformatf("%s%0d err", tag, idx), 256'(error_delay), 256'(v.exp_err));
        chk($sformatf("%s%0d spikes", tag, idx), axon_spikes, v.exp_spk);
    endtask

    // Set+tick over all 16 slots; every slot must read back empty.
    task automatic scan_empty(input string tag, input logic [3:0] start_ptr);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 8'd0, 4'd0, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("%s slot%0d spikes", tag, i), axon_spikes, 256'd0);
            chk($sformatf("%s slot%0d ptr", tag, i), 256'(slot_ptr), 256'(4'(start_ptr + 4'(i) + 4'd1)));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        //           tick  valid ax  d  set   clr  rep rdy  ptr err spikes
        tbl_a.push_back(mk(1'b0, 1'b1, 5,   1, 1'b0, 1'b0, 1,  1'b1, 0,  1'b0, 256'd0));
        tbl_a.push_back(mk(1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 1,  1'b0, 1,  1'b0, 256'd0));
        tbl_a.push_back(mk(1'b0, 1'b0, 0,   0, 1'b1, 1'b0, 1,  1'b1, 1,  1'b0, m(5)));
        tbl_a.push_back(mk(1'b0, 1'b0, 0,   0, 1'b0, 1'b1, 1,  1'b1, 1,  1'b0, m(5)));
        tbl_a.push_back(mk(1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 16, 1'b0, 1,  1'b0, m(5)));
        tbl_a.push_back(mk(1'b0, 1'b0, 0,   0, 1'b1, 1'b0, 1,  1'b1, 1,  1'b0, 256'd0));
        tbl_a.push_back(mk(1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 14, 1'b0, 15, 1'b0, 256'd0));
        tbl_a.push_back(mk(1'b0, 1'b1, 255, 3, 1'b0, 1'b0, 1,  1'b1, 15, 1'b0, 256'd0));
        tbl_a.push_back(mk(1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 3,  1'b0, 2,  1'b0, 256'd0));
        tbl_a.push_back(mk(1'b0, 1'b0, 0,   0, 1'b1, 1'b0, 1,  1'b1, 2,  1'b0, m(255)));
        tbl_a.push_back(mk(1'b0, 1'b0, 0,   0, 1'b0, 1'b1, 1,  1'b1, 2,  1'b0, m(255)));
        tbl_a.push_back(mk(1'b0, 1'b1, 10,  0, 1'b0, 1'b0, 1,  1'b1, 2,  1'b1, m(255)));
        tbl_a.push_back(mk(1'b0, 1'b0, 0,   0, 1'b0, 1'b0, 1,  1'b1, 2,  1'b0, m(255)));

        tbl_b.push_back(mk(1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 2,  1'b0, 4,  1'b0, 256'd0));
        tbl_b.push_back(mk(1'b1, 1'b1, 7,   2, 1'b0, 1'b0, 1,  1'b0, 5,  1'b0, 256'd0));
        tbl_b.push_back(mk(1'b0, 1'b1, 7,   2, 1'b0, 1'b0, 1,  1'b1, 5,  1'b0, 256'd0));
        tbl_b.push_back(mk(1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 1,  1'b0, 6,  1'b0, 256'd0));
        tbl_b.push_back(mk(1'b0, 1'b0, 0,   0, 1'b1, 1'b0, 1,  1'b1, 6,  1'b0, 256'd0));
        tbl_b.push_back(mk(1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 1,  1'b0, 7,  1'b0, 256'd0));
        tbl_b.push_back(mk(1'b0, 1'b0, 0,   0, 1'b1, 1'b0, 1,  1'b1, 7,  1'b0, m(7)));
        tbl_b.push_back(mk(1'b0, 1'b0, 0,   0, 1'b0, 1'b1, 1,  1'b1, 7,  1'b0, m(7)));
        tbl_b.push_back(mk(1'b0, 1'b1, 0,   1, 1'b0, 1'b0, 1,  1'b1, 7,  1'b0, m(7)));
        tbl_b.push_back(mk(1'b0, 1'b1, 128, 1, 1'b0, 1'b0, 1,  1'b1, 7,  1'b0, m(7)));
        tbl_b.push_back(mk(1'b0, 1'b1, 0,   1, 1'b0, 1'b0, 1,  1'b1, 7,  1'b0, m(7)));
        tbl_b.push_back(mk(1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 1,  1'b0, 8,  1'b0, m(7)));
        tbl_b.push_back(mk(1'b0, 1'b0, 0,   0, 1'b1, 1'b1, 1,  1'b1, 8,  1'b0, m(0) | m(128)));
        tbl_b.push_back(mk(1'b0, 1'b0, 0,   0, 1'b1, 1'b0, 1,  1'b1, 8,  1'b0, 256'd0));
        tbl_b.push_back(mk(1'b0, 1'b1, 1,   1, 1'b0, 1'b0, 1,  1'b1, 8,  1'b0, 256'd0));
        tbl_b.push_back(mk(1'b0, 1'b1, 2,  11, 1'b0, 1'b0, 1,  1'b1, 8,  1'b0, 256'd0));
        tbl_b.push_back(mk(1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 1,  1'b0, 9,  1'b0, 256'd0));
        tbl_b.push_back(mk(1'b0, 1'b0, 0,   0, 1'b1, 1'b0, 1,  1'b1, 9,  1'b0, m(1)));

        // Power-on reset and release.
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset spikes", axon_spikes, 256'd0);
        chk("reset ptr", 256'(slot_ptr), 256'd0);
        chk("reset ready", 256'(packet_ready), 256'd1);
        chk("reset err", 256'(error_delay), 256'd0);

        for (int i = 0; i < tbl_a.size(); i++) run_vec("A", i, tbl_a[i]);
        scan_empty("delay0 scan", 4'd2);
        for (int i = 0; i < tbl_b.size(); i++) run_vec("B", i, tbl_b[i]);

        // Mid-operation reset must clear outputs without waiting for an edge.
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst spikes", axon_spikes, 256'd0);
        chk("async rst ptr", 256'(slot_ptr), 256'd0);
        chk("async rst err", 256'(error_delay), 256'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post rst ready", 256'(packet_ready), 256'd1);
        scan_empty("post rst scan", 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axon_spike_scheduler.md
Name: axon_spike_scheduler

Overview:
- Circular per-tick axon spike buffer that feeds neuron_grid its axon_spikes vector.
- Incoming spike packets carry a target axon and a delivery delay, and set one bit in a future tick slot.
- neuron_grid pulls the current slot with scheduler_set and clears it with scheduler_clr.
- The global tick pulse advances the slot pointer.

Parameters:
- NUM_AXONS, 256, width of each slot and of axon_spikes.
- AXON_W, 8, axon index width (log2 NUM_AXONS).
- NUM_SLOTS, 16, number of tick slots (power of two).
- DELAY_W, 4, delay/pointer width (log2 NUM_SLOTS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle pulse marking start of a new tick.
- packet_valid  in  1  spike packet offered.
- packet_ready  out  1  scheduler can accept packet this cycle.
- packet_axon  in  AXON_W  destination axon index.
- packet_delay  in  DELAY_W  ticks until delivery; legal 1..NUM_SLOTS-1.
- scheduler_set  in  1  from neuron_grid: load current slot onto axon_spikes.
- scheduler_clr  in  1  from neuron_grid: clear current slot.
- axon_spikes  out  NUM_AXONS  registered spike vector for current tick.
- slot_ptr  out  DELAY_W  current slot index.
- error_delay  out  1  one-cycle pulse: accepted packet had delay 0 and was dropped.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all slots 0, slot_ptr 0, axon_spikes 0, error_delay 0. packet_ready is 1 once reset is deasserted.
- Storage: NUM_SLOTS x NUM_AXONS bit array, slot[k][a].
- Pointer: on tick=1, slot_ptr <= (slot_ptr+1) mod NUM_SLOTS. Wraps 15 -> 0.
- Packet handshake:
  - packet_ready = ~tick (combinational).
  - A transfer occurs when packet_valid & packet_ready.
  - The producer holds packet fields stable until transfer.
- Accepted packet with delay d>=1: slot[(slot_ptr+d) mod NUM_SLOTS][packet_axon] <= 1.
  - OR semantics: a duplicate packet is idempotent.
  - The target never equals slot_ptr, so a write can never collide with scheduler_clr.
- Accepted packet with delay 0: no slot modified; error_delay=1 next cycle for exactly one cycle.
- Packet stalled by tick: the target is computed from the post-increment slot_ptr in the cycle it is accepted. The producer is responsible for that offset.
- scheduler_set=1 at an edge: axon_spikes <= slot[slot_ptr] (1-cycle latency). Otherwise axon_spikes holds.
- scheduler_clr=1 at an edge: slot[slot_ptr] <= 0.
- set and clr in the same cycle: axon_spikes captures the pre-clear contents; the slot is cleared.
- tick with set/clr in the same cycle: set/clr act on the old slot_ptr; the pointer increments at the same edge.
- tick with a stalled packet: no write that cycle; the packet is accepted in the following cycle if still valid.
- Reset mid-operation: all pending spikes are discarded immediately. The next tick starts from slot 1.
- No other state. No FSM beyond pointer + handshake; a 2-state view is IDLE (ready) / TICK (not ready, 1 cycle).

Test Plan:
1. Reset, then release -> axon_spikes=0, slot_ptr=0, packet_ready=1, error_delay=0.
2. At slot_ptr=0: packet axon=5 delay=1, then tick, then scheduler_set -> next cycle axon_spikes has only bit 5 set, slot_ptr=1. Then scheduler_clr; 16 ticks later scheduler_set -> axon_spikes=0.
3. Wrap-around: advance slot_ptr to 15, send axon=255 delay=3 -> slot 2 holds bit 255. After 3 ticks scheduler_set -> axon_spikes[255]=1, all others 0.
4. Illegal delay: packet axon=10 delay=0 -> error_delay pulses exactly 1 cycle. A subsequent scan of all 16 slots via set shows bit 10 never set.
5. Stall: packet_valid with axon=7 delay=2 in the same cycle as tick at slot_ptr=4 -> packet_ready=0 that cycle. The packet is accepted next cycle into slot 7 (5+2); verify after 2 ticks.
6. Simultaneous set+clr at a slot holding axons {0,128} -> axon_spikes shows {0,128}. A second set in the next cycle -> axon_spikes=0.
7. Reset mid-operation: pending spikes in slots 3 and 9, assert reset for 1 cycle -> all slots empty, slot_ptr=0, axon_spikes=0 immediately (asynchronous).
